// File: rtl/qnna_pkg.sv
// qnna_pkg: shared types and constants for the QNNA job controller.
//   ch_state_e    per-channel job state (IDLE/START/BUSY)
//   CTRL_*        bit positions inside the 32-bit control word
//   ST_*_LSB      lane offsets of the packed 32-bit status word
//   popcnt8()     number of set bits in an 8-bit vector
package qnna_pkg;

  typedef enum logic [1:0] {
    CH_IDLE  = 2'd0,
    CH_START = 2'd1,
    CH_BUSY  = 2'd2
  } ch_state_e;

  localparam int unsigned CTRL_RELU   = 0;
  localparam int unsigned CTRL_INT_EN = 3;
  localparam int unsigned CTRL_TO_EN  = 4;

  localparam int unsigned ST_DONE_LSB = 0;
  localparam int unsigned ST_BUSY_LSB = 8;
  localparam int unsigned ST_PEND_LSB = 16;
  localparam int unsigned ST_TOUT_LSB = 24;

  function automatic logic [3:0] popcnt8(input logic [7:0] v);
    logic [3:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cnt = cnt + {3'b000, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/qnna_ch_fsm.sv
// qnna_ch_fsm: one MAC channel's job FSM with a one-deep pending-kick slot,
// a saturating watchdog and sticky write-1-to-clear done/timeout flags.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   kick_i         start request (queued if the channel is already running)
//   clr_i          W1C pulse for done/tout (a same-cycle set wins)
//   mac_done_i     completion pulse from the engine (ignored outside BUSY)
//   to_en_i        watchdog enable
//   to_lim_i       watchdog limit, 0 disables
//   mac_start_o    one-cycle launch pulse (channel in START)
//   busy_o         channel in START or BUSY
//   pend_o         queued kick present
//   done_o/tout_o  sticky flags
//   done_evt_o     completion accepted this cycle (feeds the job counter)
module qnna_ch_fsm
  import qnna_pkg::*;
#(
  parameter int unsigned TO_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            kick_i,
  input  logic            clr_i,
  input  logic            mac_done_i,
  input  logic            to_en_i,
  input  logic [TO_W-1:0] to_lim_i,
  output logic            mac_start_o,
  output logic            busy_o,
  output logic            pend_o,
  output logic            done_o,
  output logic            tout_o,
  output logic            done_evt_o
);

  ch_state_e       state_q, state_d;
  logic            pend_q, pend_d;
  logic            done_q, done_d;
  logic            tout_q, tout_d;
  logic [TO_W-1:0] wd_q, wd_d;
  logic [TO_W-1:0] wd_inc;
  logic            wd_hit;

  // wd_q holds the count of completed BUSY cycles; the value for the current
  // cycle is one more, so the first BUSY cycle compares as count 1.
  assign wd_inc = (wd_q == '1) ? wd_q : wd_q + 1'b1;
  assign wd_hit = to_en_i && (to_lim_i != '0) && (wd_inc == to_lim_i);

  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    wd_d       = wd_q;
    done_d     = done_q & ~clr_i;
    tout_d     = tout_q & ~clr_i;
    done_evt_o = 1'b0;
    unique case (state_q)
      CH_IDLE: begin
        if (kick_i) state_d = CH_START;
      end
      CH_START: begin
        wd_d    = '0;
        state_d = CH_BUSY;
        if (kick_i) pend_d = 1'b1;
      end
      CH_BUSY: begin
        wd_d = wd_inc;
        if (mac_done_i) begin
          done_d     = 1'b1;
          done_evt_o = 1'b1;
          // A kick arriving with the completion is latched and consumed at once.
          if (pend_q || kick_i) begin
            state_d = CH_START;
            pend_d  = 1'b0;
          end else begin
            state_d = CH_IDLE;
          end
        end else if (wd_hit) begin
          state_d = CH_IDLE;
          tout_d  = 1'b1;
          pend_d  = 1'b0;
        end else if (kick_i) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CH_IDLE;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
      tout_q  <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
      tout_q  <= tout_d;
      wd_q    <= wd_d;
    end
  end

  assign mac_start_o = (state_q == CH_START);
  assign busy_o      = (state_q != CH_IDLE);
  assign pend_o      = pend_q;
  assign done_o      = done_q;
  assign tout_o      = tout_q;

endmodule

// File: rtl/qnna_job_ctrl.sv
// qnna_job_ctrl: multi-channel job controller for the QNNA MAC engines.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   kick_i         per-channel start request
//   clr_i          per-channel W1C for done/tout
//   ctrl_i         bit0 relu_en, bit3 int_en, bit4 timeout_en
//   irq_mask_i     per-channel interrupt enable
//   to_lim_i       watchdog limit (0 disables)
//   mac_done_i     per-channel engine completion pulse
//   mac_start_o    per-channel launch pulse
//   relu_en_o      ctrl_i[0] passthrough
//   busy_o/pend_o/done_o/tout_o  per-channel status
//   status_o       {tout, pend, busy, done}, 8-bit lanes, unused lanes zero
//   job_cnt_o      wrapping count of all completions
//   irq_o          masked interrupt from the sticky flags
module qnna_job_ctrl
  import qnna_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned TO_W   = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] kick_i,
  input  logic [NUM_CH-1:0] clr_i,
  input  logic [31:0]       ctrl_i,
  input  logic [NUM_CH-1:0] irq_mask_i,
  input  logic [TO_W-1:0]   to_lim_i,
  input  logic [NUM_CH-1:0] mac_done_i,
  output logic [NUM_CH-1:0] mac_start_o,
  output logic              relu_en_o,
  output logic [NUM_CH-1:0] busy_o,
  output logic [NUM_CH-1:0] pend_o,
  output logic [NUM_CH-1:0] done_o,
  output logic [NUM_CH-1:0] tout_o,
  output logic [31:0]       status_o,
  output logic [CNT_W-1:0]  job_cnt_o,
  output logic              irq_o
);

  logic [NUM_CH-1:0] done_evt;
  logic [CNT_W-1:0]  job_cnt_q, job_cnt_d;
  logic              unused_ctrl;

  assign unused_ctrl = ^{ctrl_i[31:5], ctrl_i[2:1]};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    qnna_ch_fsm #(
      .TO_W(TO_W)
    ) u_ch (
      .clk        (clk),
      .rst_n      (rst_n),
      .kick_i     (kick_i[g]),
      .clr_i      (clr_i[g]),
      .mac_done_i (mac_done_i[g]),
      .to_en_i    (ctrl_i[CTRL_TO_EN]),
      .to_lim_i   (to_lim_i),
      .mac_start_o(mac_start_o[g]),
      .busy_o     (busy_o[g]),
      .pend_o     (pend_o[g]),
      .done_o     (done_o[g]),
      .tout_o     (tout_o[g]),
      .done_evt_o (done_evt[g])
    );
  end

  assign job_cnt_d = job_cnt_q + CNT_W'(popcnt8(8'(done_evt)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      job_cnt_q <= '0;
    end else begin
      job_cnt_q <= job_cnt_d;
    end
  end

  always_comb begin
    status_o = '0;
    status_o[ST_DONE_LSB +: 8] = 8'(done_o);
    status_o[ST_BUSY_LSB +: 8] = 8'(busy_o);
    status_o[ST_PEND_LSB +: 8] = 8'(pend_o);
    status_o[ST_TOUT_LSB +: 8] = 8'(tout_o);
  end

  assign job_cnt_o = job_cnt_q;
  assign relu_en_o = ctrl_i[CTRL_RELU];
  assign irq_o     = ctrl_i[CTRL_INT_EN] & (|((done_o | tout_o) & irq_mask_i));

endmodule

// File: tb/tb_qnna_job_ctrl.sv
// tb_qnna_job_ctrl: directed self-checking bench for qnna_job_ctrl.
module tb_qnna_job_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  kick_i, clr_i, irq_mask_i, mac_done_i;
  logic [31:0] ctrl_i;
  logic [15:0] to_lim_i;
  logic [3:0]  mac_start_o, busy_o, pend_o, done_o, tout_o;
  logic        relu_en_o, irq_o;
  logic [31:0] status_o;
  logic [15:0] job_cnt_o;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  qnna_job_ctrl #(
    .NUM_CH(4),
    .TO_W  (16),
    .CNT_W (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kick_i     (kick_i),
    .clr_i      (clr_i),
    .ctrl_i     (ctrl_i),
    .irq_mask_i (irq_mask_i),
    .to_lim_i   (to_lim_i),
    .mac_done_i (mac_done_i),
    .mac_start_o(mac_start_o),
    .relu_en_o  (relu_en_o),
    .busy_o     (busy_o),
    .pend_o     (pend_o),
    .done_o     (done_o),
    .tout_o     (tout_o),
    .status_o   (status_o),
    .job_cnt_o  (job_cnt_o),
    .irq_o      (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs set before the call are sampled on this edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst_n = 1'b0; kick_i = '0; clr_i = '0; irq_mask_i = '0;
    mac_done_i = '0; ctrl_i = 32'h0000_0001; to_lim_i = 16'd0;
    step(); step();
    check("rst_busy",   {28'd0, busy_o}, 32'h0);
    check("rst_done",   {28'd0, done_o}, 32'h0);
    check("rst_start",  {28'd0, mac_start_o}, 32'h0);
    check("rst_cnt",    {16'd0, job_cnt_o}, 32'h0);
    check("rst_status", status_o, 32'h0);
    check("rst_irq",    {31'd0, irq_o}, 32'h0);
    check("relu_en",    {31'd0, relu_en_o}, 32'h1);
    rst_n = 1'b1;
    step();

    // Single job on ch0
    kick_i = 4'b0001; step(); kick_i = '0;
    check("j1_start", {28'd0, mac_start_o}, 32'h1);
    check("j1_busy0", {28'd0, busy_o}, 32'h1);
    step();
    check("j1_start_low", {28'd0, mac_start_o}, 32'h0);
    for (int i = 0; i < 7; i++) step();
    check("j1_busy_mid", {28'd0, busy_o}, 32'h1);
    mac_done_i = 4'b0001; step(); mac_done_i = '0;
    check("j1_done", {28'd0, done_o}, 32'h1);
    check("j1_idle", {28'd0, busy_o}, 32'h0);
    check("j1_cnt",  {16'd0, job_cnt_o}, 32'd1);

    // Queued kick on ch1, third kick dropped
    kick_i = 4'b0010; step(); kick_i = '0; step();
    kick_i = 4'b0010; step(); kick_i = '0;
    check("q_pend", {28'd0, pend_o}, 32'h2);
    kick_i = 4'b0010; step(); kick_i = '0;
    check("q_pend_hold", {28'd0, pend_o}, 32'h2);
    mac_done_i = 4'b0010; step(); mac_done_i = '0;
    check("q_relaunch", {28'd0, mac_start_o}, 32'h2);
    check("q_busy",     {28'd0, busy_o}, 32'h2);
    check("q_pend_clr", {28'd0, pend_o}, 32'h0);
    check("q_cnt1",     {16'd0, job_cnt_o}, 32'd2);
    step(); step();
    mac_done_i = 4'b0010; step(); mac_done_i = '0;
    check("q_idle", {28'd0, busy_o}, 32'h0);
    check("q_cnt2", {16'd0, job_cnt_o}, 32'd3);
    step();
    check("q_no_start", {28'd0, mac_start_o}, 32'h0);

    // Watchdog on ch2, limit 5
    ctrl_i = 32'h0000_0010; to_lim_i = 16'd5;
    kick_i = 4'b0100; step(); kick_i = '0;
    for (int i = 0; i < 5; i++) step();
    check("wd_pre_tout", {28'd0, tout_o}, 32'h0);
    check("wd_pre_busy", {28'd0, busy_o}, 32'h4);
    step();
    check("wd_tout", {28'd0, tout_o}, 32'h4);
    check("wd_idle", {28'd0, busy_o}, 32'h0);
    check("wd_done", {31'd0, done_o[2]}, 32'h0);
    check("wd_cnt",  {16'd0, job_cnt_o}, 32'd3);

    // Completion on the exact watchdog-hit cycle (ch3)
    kick_i = 4'b1000; step(); kick_i = '0;
    for (int i = 0; i < 5; i++) step();
    mac_done_i = 4'b1000; step(); mac_done_i = '0;
    check("col_done", {31'd0, done_o[3]}, 32'h1);
    check("col_tout", {31'd0, tout_o[3]}, 32'h0);
    check("col_cnt",  {16'd0, job_cnt_o}, 32'd4);

    // IRQ and write-1-to-clear
    ctrl_i = 32'h0000_0018; irq_mask_i = 4'b0001; #1;
    check("status_pack", status_o, 32'h0400_000B);
    check("irq_on", {31'd0, irq_o}, 32'h1);
    clr_i = 4'b0001; step(); clr_i = '0;
    check("irq_cleared", {31'd0, irq_o}, 32'h0);
    check("w1c_done",    {28'd0, done_o}, 32'hA);
    kick_i = 4'b0001; step(); kick_i = '0; step();
    mac_done_i = 4'b0001; clr_i = 4'b0001; step();
    mac_done_i = '0; clr_i = '0;
    check("set_wins", {31'd0, done_o[0]}, 32'h1);
    check("irq_again", {31'd0, irq_o}, 32'h1);
    check("irq_cnt", {16'd0, job_cnt_o}, 32'd5);
    ctrl_i = 32'h0000_0010; #1;
    check("irq_int_off", {31'd0, irq_o}, 32'h0);
    ctrl_i = 32'h0000_0018; irq_mask_i = 4'b0100; clr_i = 4'b0001; step(); clr_i = '0;
    check("irq_tout", {31'd0, irq_o}, 32'h1);
    clr_i = 4'b1111; step(); clr_i = '0;
    check("clr_all", status_o, 32'h0);

    // Reset mid-job with three channels busy and pending
    kick_i = 4'b0111; step(); step(); kick_i = '0;
    check("mid_busy", {28'd0, busy_o}, 32'h7);
    check("mid_pend", {28'd0, pend_o}, 32'h7);
    rst_n = 1'b0; step(); rst_n = 1'b1;
    check("mrst_status", status_o, 32'h0);
    check("mrst_start",  {28'd0, mac_start_o}, 32'h0);
    check("mrst_cnt",    {16'd0, job_cnt_o}, 32'h0);
    mac_done_i = 4'b0111; step(); mac_done_i = '0;
    check("mrst_ignore_done", {28'd0, done_o}, 32'h0);
    check("mrst_ignore_cnt",  {16'd0, job_cnt_o}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
